// File: rtl/amp_sqrt_sched_pkg.sv
// Shared types and defaults for the amplitude square-root scheduler.
// States, default channel count, amplitude width and watchdog limit.
package amp_sqrt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int NCH_DEF = 4;
    localparam int M_DEF   = 12;
    localparam int TMO_DEF = 64;
    localparam int CHW     = 3;

endpackage

// File: rtl/amp_sqrt_sched_if.sv
// Request, root-unit and result signals of the scheduler, bundled for port use.
// tmo_err exists only when AMP_SQRT_SCHED_TIMEOUT_EN is defined.
interface amp_sqrt_sched_if
    import amp_sqrt_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int M   = M_DEF
);
    logic                 ce;
    logic [NCH-1:0]       req_st;
    logic [NCH*2*M-1:0]   req_q;
    logic                 ovf_clr;
    logic                 sq_st;
    logic [2*M-1:0]       sq_q;
    logic                 sq_ok;
    logic [M-1:0]         sq_res;
    logic [NCH*M-1:0]     amp_out;
    logic [NCH-1:0]       amp_vld;
    logic [CHW-1:0]       cur_ch;
    logic                 busy;
    logic [NCH-1:0]       ovf;
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
    logic                 tmo_err;
`endif

    modport master (
        output ce, req_st, req_q, ovf_clr, sq_ok, sq_res,
        input  sq_st, sq_q, amp_out, amp_vld, cur_ch, busy, ovf
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
        , input tmo_err
`endif
    );

    modport slave (
        input  ce, req_st, req_q, ovf_clr, sq_ok, sq_res,
        output sq_st, sq_q, amp_out, amp_vld, cur_ch, busy, ovf
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
        , output tmo_err
`endif
    );

endinterface

// File: rtl/amp_sqrt_sched_rr_pick.sv
// Combinational round-robin picker: first pending channel after ptr, wrapping.
module amp_sqrt_sched_rr_pick
    import amp_sqrt_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0] pend_i,
    input  logic [CHW-1:0] ptr_i,
    output logic [CHW-1:0] gnt_o,
    output logic           any_o
);
    logic [3:0]     base;
    logic [3:0]     idx;
    logic [NCH-1:0] rot;

    // rot[k] is the pending bit of channel (ptr+1+k) mod NCH
    always_comb begin
        base  = {1'b0, ptr_i} + 4'd1;
        rot   = NCH'({pend_i, pend_i} >> base);
        gnt_o = '0;
        any_o = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                idx   = base + 4'(k);
                if (idx >= 4'(NCH)) begin
                    idx = idx - 4'(NCH);
                end
                gnt_o = idx[CHW-1:0];
            end
        end
    end

endmodule

// File: rtl/amp_sqrt_sched.sv
// Shares one sequential square-root core among NCH channels, round-robin.
// Optional watchdog on the root core: define AMP_SQRT_SCHED_TIMEOUT_EN.
module amp_sqrt_sched
    import amp_sqrt_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int M   = M_DEF
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
    , parameter int TMO = TMO_DEF
`endif
) (
    input logic             clk,
    input logic             rst_n,
    amp_sqrt_sched_if.slave bus
);
    localparam int W = 2 * M;

    state_t         state_q, state_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [NCH-1:0] vld_q, vld_d;
    logic [W-1:0]   slot_q [NCH];
    logic [W-1:0]   slot_d [NCH];
    logic [M-1:0]   amp_q [NCH];
    logic [M-1:0]   amp_d [NCH];
    logic [W-1:0]   opnd_q, opnd_d;
    logic           st_q, st_d;
    logic [CHW-1:0] ptr_q, ptr_d;
    logic [CHW-1:0] cur_q, cur_d;
    logic [CHW-1:0] gnt;
    logic           any;
    logic           grant;
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tmo_q, tmo_d;
`endif

    amp_sqrt_sched_rr_pick #(.NCH(NCH)) u_pick (
        .pend_i (pend_q),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .any_o  (any)
    );

    assign grant = (state_q == IDLE) && any;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovf_d   = bus.ovf_clr ? '0 : ovf_q;
        vld_d   = '0;
        slot_d  = slot_q;
        amp_d   = amp_q;
        opnd_d  = opnd_q;
        st_d    = 1'b0;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = bus.ovf_clr ? 1'b0 : tmo_q;
`endif
        // A grant reads the old slot word; a coincident strobe refills the slot
        for (int i = 0; i < NCH; i++) begin
            if (grant && gnt == CHW'(i)) begin
                opnd_d    = slot_q[i];
                pend_d[i] = 1'b0;
            end
            if (bus.req_st[i]) begin
                slot_d[i] = bus.req_q[i*W +: W];
                pend_d[i] = 1'b1;
                if (pend_q[i] && !(grant && gnt == CHW'(i))) begin
                    ovf_d[i] = 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (grant) begin
                    cur_d   = gnt;
                    st_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.sq_ok) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (cur_q == CHW'(i)) begin
                            amp_d[i] = bus.sq_res;
                            vld_d[i] = 1'b1;
                        end
                    end
                    ptr_d   = cur_q;
                    state_d = IDLE;
                end
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TMO - 1)) begin
                    tmo_d   = 1'b1;
                    ptr_d   = cur_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ovf_q   <= '0;
            vld_q   <= '0;
            opnd_q  <= '0;
            st_q    <= 1'b0;
            ptr_q   <= CHW'(NCH - 1);
            cur_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                slot_q[i] <= '0;
                amp_q[i]  <= '0;
            end
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else if (bus.ce) begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            opnd_q  <= opnd_d;
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            slot_q  <= slot_d;
            amp_q   <= amp_d;
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_amp
        assign bus.amp_out[g*M +: M] = amp_q[g];
    end

    assign bus.sq_st   = st_q;
    assign bus.sq_q    = opnd_q;
    assign bus.amp_vld = vld_q;
    assign bus.cur_ch  = cur_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.ovf     = ovf_q;
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
    assign bus.tmo_err = tmo_q;
`endif

endmodule

// File: tb/tb_amp_sqrt_sched.sv
// Directed bench for amp_sqrt_sched with a behavioural root core model.
// The watchdog scenario is compiled in when AMP_SQRT_SCHED_TIMEOUT_EN is defined.
module tb_amp_sqrt_sched;
    localparam int NCH = 4;
    localparam int M   = 12;
    localparam int LAT = 5;
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
    localparam int TMO = 8;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    int   ce_div;
    int   st_clks;
    int   mcnt;
    int   skip_n;
    logic           model_ok;
    logic [M-1:0]   model_res;
    logic [2*M-1:0] mop;
    int             vld_ch[$];
    int             vld_val[$];
    logic [2*M-1:0] st_ops[$];

    amp_sqrt_sched_if #(.NCH(NCH), .M(M)) bif ();

    amp_sqrt_sched #(
        .NCH(NCH),
        .M(M)
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
        , .TMO(TMO)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    assign bif.sq_ok  = model_ok;
    assign bif.sq_res = model_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [M-1:0] isqrt(input logic [2*M-1:0] v);
        logic [M-1:0] r;
        logic [M-1:0] t;
        r = '0;
        for (int b = M - 1; b >= 0; b--) begin
            t = r;
            t[b] = 1'b1;
            if (({{M{1'b0}}, t} * {{M{1'b0}}, t}) <= v) r = t;
        end
        return r;
    endfunction

    function automatic logic [127:0] outs();
        return 128'({bif.sq_st, bif.sq_q, bif.amp_out, bif.amp_vld, bif.cur_ch, bif.busy, bif.ovf});
    endfunction

    task automatic clear_logs();
        vld_ch.delete();
        vld_val.delete();
        st_ops.delete();
        st_clks = 0;
    endtask

    task automatic model_tick();
        model_ok = 1'b0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                model_ok  = 1'b1;
                model_res = isqrt(mop);
            end
        end else if (bif.sq_st) begin
            if (skip_n > 0) skip_n--;
            else begin
                mop  = bif.sq_q;
                mcnt = LAT;
            end
        end
    endtask

    // One ce period: ce-enabled edge, then ce_div-1 edges with ce low that must not move state
    task automatic ce_step();
        logic [127:0] snap;
        bif.ce = 1'b1;
        @(posedge clk);
        #1;
        bif.ce = 1'b0;
        if (bif.sq_st) begin
            st_ops.push_back(bif.sq_q);
            st_clks++;
        end
        for (int i = 0; i < NCH; i++) begin
            if (bif.amp_vld[i]) begin
                vld_ch.push_back(i);
                vld_val.push_back(int'(bif.amp_out[i*M +: M]));
            end
        end
        model_tick();
        for (int k = 1; k < ce_div; k++) begin
            snap = outs();
            @(posedge clk);
            #1;
            if (bif.sq_st) st_clks++;
            n_vec++;
            if (outs() !== snap) begin
                n_bad++;
                $display("FAIL ce_hold: outputs %h, required %h", outs(), snap);
            end
        end
    endtask

    task automatic set_req(input int ch, input logic [2*M-1:0] v);
        bif.req_st[ch] = 1'b1;
        bif.req_q[ch*2*M +: 2*M] = v;
    endtask

    task automatic clr_req();
        bif.req_st = '0;
        bif.req_q  = '0;
    endtask

    task automatic wait_results(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (vld_ch.size() < n && k < budget) begin
            ce_step();
            k++;
        end
        n_vec++;
        if (vld_ch.size() < n) begin
            n_bad++;
            $display("FAIL %s_wait: got %0d results, required %0d", tag, vld_ch.size(), n);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bif.ce  = 1'b0;
        bif.ovf_clr = 1'b0;
        clr_req();
        ce_div  = 1;
        mcnt    = 0;
        skip_n  = 0;
        model_ok  = 1'b0;
        model_res = '0;
        mop       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", bif.busy); end
        n_vec++; if (bif.sq_st !== 1'b0) begin n_bad++; $display("FAIL rst_sq_st: got %b, required 0", bif.sq_st); end
        n_vec++; if (bif.sq_q !== 24'd0) begin n_bad++; $display("FAIL rst_sq_q: got %h, required 0", bif.sq_q); end
        n_vec++; if (bif.amp_out !== 48'd0) begin n_bad++; $display("FAIL rst_amp: got %h, required 0", bif.amp_out); end
        n_vec++; if (bif.amp_vld !== 4'd0 || bif.ovf !== 4'd0 || bif.cur_ch !== 3'd0) begin
            n_bad++; $display("FAIL rst_flags: vld=%b ovf=%b cur=%0d, required 0 0 0", bif.amp_vld, bif.ovf, bif.cur_ch);
        end
        ce_step();
        n_vec++; if (bif.busy !== 1'b0 || bif.sq_st !== 1'b0) begin
            n_bad++; $display("FAIL idle_no_req: busy=%b sq_st=%b, required 0 0", bif.busy, bif.sq_st);
        end
    endtask

    task automatic test_single();
        clear_logs();
        set_req(2, 24'd400);
        ce_step();
        clr_req();
        ce_step();
        n_vec++; if (bif.busy !== 1'b1 || bif.cur_ch !== 3'd2) begin
            n_bad++; $display("FAIL single_grant: busy=%b cur=%0d, required 1 2", bif.busy, bif.cur_ch);
        end
        wait_results(1, 40, "single");
        n_vec++; if (st_ops.size() != 1 || st_ops[0] !== 24'd400) begin
            n_bad++; $display("FAIL single_issue: %0d starts, first operand %0d, required 1 start of 400", st_ops.size(), (st_ops.size() > 0) ? st_ops[0] : 0);
        end
        n_vec++; if (vld_ch.size() != 1 || vld_ch[0] != 2 || vld_val[0] != 20) begin
            n_bad++; $display("FAIL single_result: ch=%0d val=%0d, required ch 2 val 20", (vld_ch.size() > 0) ? vld_ch[0] : -1, (vld_val.size() > 0) ? vld_val[0] : -1);
        end
        n_vec++; if (bif.busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b, required 0", bif.busy); end
        ce_step();
        n_vec++; if (bif.amp_vld !== 4'd0 || bif.amp_out[2*M +: M] !== 12'd20) begin
            n_bad++; $display("FAIL single_pulse: vld=%b amp2=%0d, required 0000 20", bif.amp_vld, bif.amp_out[2*M +: M]);
        end
    endtask

    task automatic test_simultaneous();
        int exp_ch[4]  = '{0, 1, 2, 3};
        int exp_val[4] = '{0, 12, 100, 4095};
        do_reset();
        set_req(0, 24'd0);
        set_req(1, 24'd144);
        set_req(2, 24'd10000);
        set_req(3, 24'hFFE001);
        ce_step();
        clr_req();
        wait_results(4, 80, "simul");
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (vld_ch.size() <= i || vld_ch[i] != exp_ch[i] || vld_val[i] != exp_val[i]) begin
                n_bad++; $display("FAIL simul_order%0d: ch=%0d val=%0d, required ch %0d val %0d", i,
                    (vld_ch.size() > i) ? vld_ch[i] : -1, (vld_val.size() > i) ? vld_val[i] : -1, exp_ch[i], exp_val[i]);
            end
        end
        n_vec++; if (st_ops.size() != 4 || st_ops[3] !== 24'hFFE001) begin
            n_bad++; $display("FAIL simul_fullwidth: %0d starts, last operand %h, required 4 starts ending ffe001", st_ops.size(), (st_ops.size() > 0) ? st_ops[st_ops.size()-1] : 24'd0);
        end
        n_vec++; if (bif.ovf !== 4'd0 || bif.amp_out !== {12'd4095, 12'd100, 12'd12, 12'd0}) begin
            n_bad++; $display("FAIL simul_regs: ovf=%b amp=%h, required 0000 fff06400c000", bif.ovf, bif.amp_out);
        end
    endtask

    task automatic test_overwrite();
        clear_logs();
        set_req(0, 24'd49);
        ce_step();
        clr_req();
        ce_step();
        set_req(1, 24'd100);
        ce_step();
        clr_req();
        n_vec++; if (bif.ovf !== 4'b0000) begin n_bad++; $display("FAIL ovw_first: ovf=%b, required 0000", bif.ovf); end
        set_req(1, 24'd144);
        ce_step();
        clr_req();
        n_vec++; if (bif.ovf !== 4'b0010) begin n_bad++; $display("FAIL ovw_set: ovf=%b, required 0010", bif.ovf); end
        set_req(1, 24'd144);
        bif.ovf_clr = 1'b1;
        ce_step();
        bif.ovf_clr = 1'b0;
        clr_req();
        n_vec++; if (bif.ovf !== 4'b0010) begin n_bad++; $display("FAIL ovw_set_wins: ovf=%b, required 0010", bif.ovf); end
        wait_results(2, 60, "ovw");
        n_vec++; if (vld_ch.size() != 2 || vld_ch[0] != 0 || vld_val[0] != 7 || vld_ch[1] != 1 || vld_val[1] != 12) begin
            n_bad++; $display("FAIL ovw_results: %0d results, last ch=%0d val=%0d, required ch0=7 then ch1=12", vld_ch.size(),
                (vld_ch.size() > 0) ? vld_ch[vld_ch.size()-1] : -1, (vld_val.size() > 0) ? vld_val[vld_val.size()-1] : -1);
        end
        bif.ovf_clr = 1'b1;
        ce_step();
        bif.ovf_clr = 1'b0;
        n_vec++; if (bif.ovf !== 4'b0000) begin n_bad++; $display("FAIL ovw_clear: ovf=%b, required 0000", bif.ovf); end
    endtask

    task automatic test_coincident();
        clear_logs();
        set_req(2, 24'd25);
        ce_step();
        clr_req();
        set_req(2, 24'd36);
        ce_step();
        clr_req();
        n_vec++; if (bif.ovf !== 4'd0 || st_ops.size() != 1 || st_ops[0] !== 24'd25) begin
            n_bad++; $display("FAIL coinc_grant: ovf=%b starts=%0d, required ovf 0000 and operand 25", bif.ovf, st_ops.size());
        end
        wait_results(2, 60, "coinc");
        n_vec++; if (vld_ch.size() != 2 || vld_ch[0] != 2 || vld_val[0] != 5 || vld_ch[1] != 2 || vld_val[1] != 6) begin
            n_bad++; $display("FAIL coinc_results: %0d results, required ch2=5 then ch2=6", vld_ch.size());
        end
    endtask

    task automatic test_ce_gating();
        clear_logs();
        ce_div = 4;
        set_req(3, 24'd81);
        ce_step();
        clr_req();
        wait_results(1, 40, "ce");
        n_vec++; if (st_clks != 4) begin n_bad++; $display("FAIL ce_st_width: sq_st high %0d clks, required 4", st_clks); end
        n_vec++; if (vld_ch.size() != 1 || vld_ch[0] != 3 || vld_val[0] != 9) begin
            n_bad++; $display("FAIL ce_result: %0d results, required ch3 val 9", vld_ch.size());
        end
        ce_step();
        n_vec++; if (bif.amp_vld !== 4'd0) begin n_bad++; $display("FAIL ce_vld_clear: vld=%b, required 0000", bif.amp_vld); end
        ce_div = 1;
    endtask

    task automatic test_mid_reset();
        clear_logs();
        set_req(1, 24'd64);
        ce_step();
        clr_req();
        ce_step();
        ce_step();
        n_vec++; if (bif.busy !== 1'b1) begin n_bad++; $display("FAIL mrst_wait: busy=%b, required 1", bif.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (outs() !== 128'd0) begin n_bad++; $display("FAIL mrst_async: outputs %h, required 0", outs()); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) ce_step();
        n_vec++; if (vld_ch.size() != 0 || bif.amp_out !== 48'd0 || bif.busy !== 1'b0) begin
            n_bad++; $display("FAIL mrst_late_ok: results=%0d amp=%h busy=%b, required 0 0 0", vld_ch.size(), bif.amp_out, bif.busy);
        end
    endtask

`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        skip_n = 1;
        set_req(0, 24'd100);
        set_req(1, 24'd169);
        ce_step();
        clr_req();
        repeat (9) ce_step();
        n_vec++; if (bif.busy !== 1'b1 || bif.tmo_err !== 1'b0) begin
            n_bad++; $display("FAIL tmo_early: busy=%b tmo_err=%b, required 1 0", bif.busy, bif.tmo_err);
        end
        ce_step();
        n_vec++; if (bif.busy !== 1'b0 || bif.tmo_err !== 1'b1 || bif.amp_vld !== 4'd0 || bif.amp_out !== 48'd0) begin
            n_bad++; $display("FAIL tmo_fire: busy=%b tmo_err=%b vld=%b amp=%h, required 0 1 0000 0", bif.busy, bif.tmo_err, bif.amp_vld, bif.amp_out);
        end
        wait_results(1, 40, "tmo");
        n_vec++; if (vld_ch.size() != 1 || vld_ch[0] != 1 || vld_val[0] != 13) begin
            n_bad++; $display("FAIL tmo_next: %0d results, required ch1 val 13", vld_ch.size());
        end
        bif.ovf_clr = 1'b1;
        ce_step();
        bif.ovf_clr = 1'b0;
        n_vec++; if (bif.tmo_err !== 1'b0) begin n_bad++; $display("FAIL tmo_clear: tmo_err=%b, required 0", bif.tmo_err); end
    endtask
`endif

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        st_clks = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_overwrite();
        test_coincident();
        test_ce_gating();
        test_mid_reset();
`ifdef AMP_SQRT_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
